// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: forwarding, load-use interlock and redirect flush control for a 5-stage RV32I pipeline
module pipe_hazard_unit #(
  parameter int REG_AW = 5,
  parameter bit RF_WRITE_FIRST = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              ex_redirect,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        ex_fwd_rs1,
  output logic [1:0]        ex_fwd_rs2,
  output logic              id_byp_rs1,
  output logic              id_byp_rs2,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic              ex_v, ex_wen, ex_ld, mem_v, mem_wen, wb_v, wb_wen;
  logic [REG_AW-1:0] ex_rd, mem_rd, wb_rd;
  logic              ex1, ex2, mem1, mem2, wb1, wb2, load_use;
  logic [1:0]        fwd1, fwd2;
  // source matches against in-flight producers, interlock/flush controls and next forward selects
  always_comb begin
    ex1 = id_use_rs1 && |id_rs1 && ex_v && ex_wen && ex_rd == id_rs1;
    ex2 = id_use_rs2 && |id_rs2 && ex_v && ex_wen && ex_rd == id_rs2;
    mem1 = id_use_rs1 && |id_rs1 && mem_v && mem_wen && mem_rd == id_rs1;
    mem2 = id_use_rs2 && |id_rs2 && mem_v && mem_wen && mem_rd == id_rs2;
    wb1 = id_use_rs1 && |id_rs1 && wb_v && wb_wen && wb_rd == id_rs1;
    wb2 = id_use_rs2 && |id_rs2 && wb_v && wb_wen && wb_rd == id_rs2;
    load_use = ex_ld && (ex1 || ex2);
    ifid_flush = ex_redirect;
    idex_bubble = ex_redirect || load_use;
    pc_hold = !ex_redirect && load_use;
    ifid_hold = pc_hold;
    fwd1 = ex1 ? 2'd1 : mem1 ? 2'd2 : 2'd0;
    fwd2 = ex2 ? 2'd1 : mem2 ? 2'd2 : 2'd0;
    id_byp_rs1 = !RF_WRITE_FIRST && wb1 && !ex1 && !mem1;
    id_byp_rs2 = !RF_WRITE_FIRST && wb2 && !ex2 && !mem2;
  end
  // scoreboard shift; a stalled, squashed or empty ID slot enters EX as a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_v <= 1'b0;
      mem_v <= 1'b0;
      wb_v <= 1'b0;
    end else begin
      ex_v <= id_valid && !load_use && !ex_redirect;
      mem_v <= ex_v;
      wb_v <= mem_v;
    end
    ex_rd <= id_rd;
    ex_wen <= id_wen;
    ex_ld <= id_is_load;
    mem_rd <= ex_rd;
    mem_wen <= ex_wen;
    wb_rd <= mem_rd;
    wb_wen <= mem_wen;
  end
  // forward selects follow the instruction into EX; a bubble carries no forwarding
  always_ff @(posedge clk) begin
    if (reset || idex_bubble) begin
      ex_fwd_rs1 <= 2'd0;
      ex_fwd_rs2 <= 2'd0;
    end else if (!ifid_hold) begin
      ex_fwd_rs1 <= fwd1;
      ex_fwd_rs2 <= fwd2;
    end
  end
  // saturating stall and redirect event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (ex_redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb_pipe_hazard_unit: instruction-history model check of two configurations plus directed pipeline scenarios
module tb_pipe_hazard_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_wen = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic a_pch, a_ifh, a_iff, a_bub, a_b1, a_b2, b_pch, b_ifh, b_iff, b_bub, b_b1, b_b2;
  logic [1:0] a_f1, a_f2, b_f1, b_f2;
  logic [31:0] a_sc, a_fc;
  logic [3:0] b_sc, b_fc;
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  pipe_hazard_unit dut_a (.clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .pc_hold(a_pch), .ifid_hold(a_ifh), .ifid_flush(a_iff), .idex_bubble(a_bub),
    .ex_fwd_rs1(a_f1), .ex_fwd_rs2(a_f2), .id_byp_rs1(a_b1), .id_byp_rs2(a_b2), .stall_cnt(a_sc), .flush_cnt(a_fc));

  pipe_hazard_unit #(.REG_AW(5), .RF_WRITE_FIRST(1'b0), .CNT_W(4)) dut_b (.clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_wen(id_wen), .id_is_load(id_is_load), .ex_redirect(ex_redirect), .pc_hold(b_pch),
    .ifid_hold(b_ifh), .ifid_flush(b_iff), .idex_bubble(b_bub), .ex_fwd_rs1(b_f1), .ex_fwd_rs2(b_f2),
    .id_byp_rs1(b_b1), .id_byp_rs2(b_b2), .stall_cnt(b_sc), .flush_cnt(b_fc));

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else passed++;
  endtask

  // model: the last three instructions issued past ID, index 0 = youngest (now in EX)
  logic h_v[3], h_w[3], h_ld[3];
  logic [4:0] h_rd[3];
  logic [1:0] m_f1 = 0, m_f2 = 0;
  int m_stalls = 0, m_flushes = 0;
  bit started = 0;

  function automatic int youngest(input logic u, input logic [4:0] rs);
    for (int k = 0; k < 3; k++)
      if (u && rs != 0 && h_v[k] && h_w[k] && h_rd[k] == rs) return k;
    return 3;
  endfunction

  function automatic bit stall_now();
    return h_ld[0] && (youngest(id_use_rs1, id_rs1) == 0 || youngest(id_use_rs2, id_rs2) == 0);
  endfunction

  function automatic logic [1:0] sel_of(input int y);
    return y == 0 ? 2'd1 : y == 1 ? 2'd2 : 2'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) h_v[k] = 1'b0;
      m_f1 = 0; m_f2 = 0; m_stalls = 0; m_flushes = 0; started = 1;
    end else if (started) begin
      bit st;
      st = stall_now() && !ex_redirect;
      if (st) m_stalls++;
      if (ex_redirect) m_flushes++;
      m_f1 = (st || ex_redirect) ? 2'd0 : sel_of(youngest(id_use_rs1, id_rs1));
      m_f2 = (st || ex_redirect) ? 2'd0 : sel_of(youngest(id_use_rs2, id_rs2));
      for (int k = 2; k > 0; k--) begin
        h_v[k] = h_v[k-1]; h_w[k] = h_w[k-1]; h_ld[k] = h_ld[k-1]; h_rd[k] = h_rd[k-1];
      end
      h_v[0] = id_valid && !st && !ex_redirect; h_w[0] = id_wen; h_ld[0] = id_is_load; h_rd[0] = id_rd;
    end
  end

  always @(negedge clk) if (started) begin
    bit st, bub;
    int y1, y2;
    y1 = youngest(id_use_rs1, id_rs1);
    y2 = youngest(id_use_rs2, id_rs2);
    st = stall_now() && !ex_redirect;
    bub = st || ex_redirect;
    chk("a_pc_hold", a_pch, st); chk("a_ifid_hold", a_ifh, st);
    chk("a_ifid_flush", a_iff, ex_redirect); chk("a_idex_bubble", a_bub, bub);
    chk("b_pc_hold", b_pch, st); chk("b_idex_bubble", b_bub, bub);
    chk("a_fwd1", a_f1, m_f1); chk("a_fwd2", a_f2, m_f2);
    chk("b_fwd1", b_f1, m_f1); chk("b_fwd2", b_f2, m_f2);
    chk("a_byp1", a_b1, 0); chk("a_byp2", a_b2, 0);
    chk("b_byp1", b_b1, y1 == 2); chk("b_byp2", b_b2, y2 == 2);
    chk("a_stall_cnt", a_sc, m_stalls); chk("a_flush_cnt", a_fc, m_flushes);
    chk("b_stall_cnt", b_sc, m_stalls > 15 ? 15 : m_stalls);
    chk("b_flush_cnt", b_fc, m_flushes > 15 ? 15 : m_flushes);
  end

  task automatic ins(input logic v, input int rd, input logic w, input logic ld, input int r1, input logic u1,
                     input int r2, input logic u2, input logic rdr = 1'b0, input logic rst = 1'b0);
    @(posedge clk); #1;
    id_valid = v; id_rd = 5'(rd); id_wen = w; id_is_load = ld; id_rs1 = 5'(r1); id_use_rs1 = u1;
    id_rs2 = 5'(r2); id_use_rs2 = u2; ex_redirect = rdr; reset = rst;
    #3;
  endtask

  task automatic nop(input logic rdr = 1'b0);
    ins(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, rdr);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    nop();
    chk("reset_pc_hold", a_pch, 0); chk("reset_fwd1", a_f1, 0); chk("reset_stall_cnt", a_sc, 0);
    ins(1, 1, 1, 0, 0, 1, 0, 0);
    ins(1, 2, 1, 0, 1, 1, 0, 0);
    chk("t1_no_stall", a_pch, 0);
    nop();
    chk("t1_fwd_ex", a_f1, 1); chk("t1_stall_cnt", a_sc, 0);
    ins(1, 1, 1, 0, 0, 1, 0, 0);
    nop();
    ins(1, 3, 1, 0, 1, 1, 1, 1);
    nop();
    chk("t2_fwd1_mem", a_f1, 2); chk("t2_fwd2_mem", a_f2, 2);
    ins(1, 5, 1, 0, 0, 1, 0, 0);
    ins(1, 5, 1, 0, 0, 1, 0, 0);
    ins(1, 6, 1, 0, 5, 1, 0, 0);
    nop();
    chk("multi_youngest", a_f1, 1);
    ins(1, 4, 1, 1, 0, 1, 0, 0);
    ins(1, 5, 1, 0, 4, 1, 0, 0);
    chk("t3_pc_hold", a_pch, 1); chk("t3_ifid_hold", a_ifh, 1); chk("t3_bubble", a_bub, 1);
    ins(1, 5, 1, 0, 4, 1, 0, 0);
    chk("t3_released", a_pch, 0);
    nop();
    chk("t3_fwd_after_stall", a_f1, 2); chk("t3_stall_cnt", a_sc, 1);
    ins(1, 8, 1, 1, 0, 1, 0, 0);
    ins(1, 9, 1, 0, 8, 1, 0, 0, 1'b1);
    chk("t4_flush", a_iff, 1); chk("t4_bubble", a_bub, 1); chk("t4_pc_hold", a_pch, 0);
    nop();
    chk("t4_stall_cnt", a_sc, 1); chk("t4_flush_cnt", a_fc, 1);
    ins(1, 0, 1, 0, 0, 1, 0, 0);
    ins(1, 6, 1, 0, 0, 1, 0, 0);
    chk("t5_no_stall", a_pch, 0);
    nop();
    chk("t5_no_fwd", a_f1, 0);
    ins(1, 1, 1, 0, 0, 1, 0, 0);
    nop();
    nop();
    ins(1, 7, 1, 0, 1, 1, 0, 0);
    chk("t6_byp_b", b_b1, 1); chk("t6_byp_a", a_b1, 0);
    nop();
    chk("t6_fwd_b", b_f1, 0);
    ins(1, 9, 1, 1, 0, 1, 0, 0);
    ins(1, 10, 1, 0, 9, 1, 0, 0, 1'b0, 1'b1);
    chk("t7_stalling", a_pch, 1);
    nop();
    chk("t7_pc_hold", a_pch, 0); chk("t7_bubble", a_bub, 0); chk("t7_stall_cnt", a_sc, 0);
    chk("t7_flush_cnt", a_fc, 0); chk("t7_fwd1", a_f1, 0);
    repeat (16) nop(1'b1);
    nop();
    chk("t8_sat_b", b_fc, 15); chk("t8_count_a", a_fc, 16);
    nop();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
